// File: rtl/store_aligner.sv
// store_aligner: turns one execute-stage store (byte address, rs2, funct3)
// into one or two word-aligned memory writes with byte strobes, and stalls
// the pipeline until the last write has been acknowledged.
module store_aligner #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [2:0]        funct3,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    output logic              stall,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic              accept;
    logic              f3_valid;
    logic [3:0]        byte_mask;
    logic [31:0]       masked_data;
    logic [63:0]       shifted_next;
    logic [7:0]        strobe_next;

    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       mem_wdata_reg;
    logic [3:0]        mem_wstrb_reg;
    logic [31:0]       hi_data_reg;
    logic [3:0]        hi_strb_reg;
    logic              split_reg;
    logic              done_reg;
    logic              err_reg;

    assign accept = st_valid && st_ready;

    // Decode the store width into a byte mask; unknown encodings are rejected.
    always_comb begin
        byte_mask = 4'b0000;
        f3_valid  = 1'b1;
        case (funct3)
            3'b000:  byte_mask = 4'b0001;
            3'b001:  byte_mask = 4'b0011;
            3'b010:  byte_mask = 4'b1111;
            default: f3_valid  = 1'b0;
        endcase
    end

    // Keep only the bytes the width covers so uncovered lanes write as zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
            assign masked_data[8*gi +: 8] = byte_mask[gi] ? st_data[8*gi +: 8] : 8'h00;
        end
    endgenerate

    // Shift data and strobe by the byte offset across a two-word window;
    // anything landing in the upper word means the store crosses a boundary.
    assign shifted_next = {32'h0, masked_data} << {st_addr[1:0], 3'b000};
    assign strobe_next  = {4'b0000, byte_mask} << st_addr[1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, advance on each acknowledged write.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept && f3_valid) begin
                    state_next = FIRST;
                end
            end
            FIRST: begin
                if (mem_ack) begin
                    state_next = split_reg ? SECOND : IDLE;
                end
            end
            SECOND: begin
                if (mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status outputs derived from the current state.
    always_comb begin
        mem_req  = (state_reg != IDLE);
        stall    = (state_reg != IDLE);
        st_ready = (state_reg == IDLE) && !rst;
    end

    // Write beat registers: load the first beat at accept, swap in the upper
    // beat when the first one is acknowledged on a split store.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= '0;
            hi_data_reg   <= '0;
            hi_strb_reg   <= '0;
            split_reg     <= 1'b0;
        end else if (state_reg == IDLE && accept && f3_valid) begin
            mem_addr_reg  <= {st_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_reg <= shifted_next[31:0];
            mem_wstrb_reg <= strobe_next[3:0];
            hi_data_reg   <= shifted_next[63:32];
            hi_strb_reg   <= strobe_next[7:4];
            split_reg     <= |strobe_next[7:4];
        end else if (state_reg == FIRST && mem_ack && split_reg) begin
            mem_addr_reg  <= mem_addr_reg + ADDR_W'(4);
            mem_wdata_reg <= hi_data_reg;
            mem_wstrb_reg <= hi_strb_reg;
        end
    end

    // Completion pulses: done after the final ack or after a rejected funct3.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            done_reg <= (accept && !f3_valid)
                     || (state_reg == FIRST && mem_ack && !split_reg)
                     || (state_reg == SECOND && mem_ack);
            err_reg  <= accept && !f3_valid;
        end
    end

    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wstrb = mem_wstrb_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_store_aligner.sv
// Testbench for store_aligner: a byte-level model predicts the write beats
// and completion cycle of each store; a memory responder acks with a
// programmable number of wait cycles and compares beats as they are acked.
module tb_store_aligner;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  funct3;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        stall;
    logic        done;
    logic        err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } beat_t;

    typedef struct {
        int cyc;
        bit is_err;
    } done_t;

    beat_t beat_q[$];
    done_t done_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int ack_wait = 0;
    int wcnt     = 0;
    bit hold_ok  = 0;
    bit drv_en   = 1;
    bit force_ack = 0;
    beat_t snap;

    store_aligner #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .funct3    (funct3),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .stall     (stall),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory responder and output monitor, evaluated between clock edges.
    always @(negedge clk) begin
        if (rst) begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end else if (!drv_en) begin
            mem_ack = force_ack;
        end else begin
            if (mem_ack) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end
            if (mem_req) begin
                check("stall_busy", stall, 1);
                check("ready_busy", st_ready, 0);
                if (beat_q.size() == 0) begin
                    if (!hold_ok) check("unexpected_req", mem_req, 0);
                end else begin
                    if (wcnt == 0) begin
                        snap.addr  = mem_addr;
                        snap.wdata = mem_wdata;
                        snap.wstrb = mem_wstrb;
                    end else begin
                        check("hold_addr", mem_addr, snap.addr);
                        check("hold_wdata", mem_wdata, snap.wdata);
                        check("hold_wstrb", mem_wstrb, snap.wstrb);
                    end
                    if (wcnt >= ack_wait) begin
                        beat_t e;
                        e = beat_q.pop_front();
                        check("wr_addr", mem_addr, e.addr);
                        check("wr_wdata", mem_wdata, e.wdata);
                        check("wr_wstrb", mem_wstrb, e.wstrb);
                        $display("write addr=%h wdata=%h wstrb=%b", mem_addr, mem_wdata, mem_wstrb);
                        mem_ack = 1'b1;
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                done_t d;
                d = done_q.pop_front();
                check("done_cycle", cyc, d.cyc);
                check("err_flag", err, d.is_err);
                $display("done cycle=%0d err=%0b", cyc, err);
            end
        end
        if (err && !done) check("err_without_done", err, 0);
    end

    // Present one store, predict its beats and completion, and return once accepted.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] f, input bit abandon);
        beat_t b0, b1;
        bit    split = 0;
        bit    valid;
        bit    ok = 0;
        int    nb;
        int    p;
        int    n;
        valid    = (f <= 3'd2);
        nb       = (f == 3'd0) ? 1 : ((f == 3'd1) ? 2 : 4);
        b0.addr  = {a[31:2], 2'b00};
        b0.wdata = '0;
        b0.wstrb = '0;
        b1.addr  = b0.addr + 32'd4;
        b1.wdata = '0;
        b1.wstrb = '0;
        if (valid) begin
            for (int k = 0; k < nb; k++) begin
                p = int'(a[1:0]) + k;
                if (p < 4) begin
                    b0.wdata[8*p +: 8] = d[8*k +: 8];
                    b0.wstrb[p] = 1'b1;
                end else begin
                    b1.wdata[8*(p-4) +: 8] = d[8*k +: 8];
                    b1.wstrb[p-4] = 1'b1;
                    split = 1;
                end
            end
            beat_q.push_back(b0);
            if (split && !abandon) beat_q.push_back(b1);
        end
        @(negedge clk);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        funct3   = f;
        for (int i = 0; i < 200; i++) begin
            if (st_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("accept_timeout", st_ready, 1);
        n = cyc;
        $display("store addr=%h data=%h funct3=%b accepted cycle=%0d", a, d, f, n);
        if (!valid) done_q.push_back('{n + 1, 1'b1});
        else if (!abandon) done_q.push_back('{n + 2 + int'(split) + ack_wait * (1 + int'(split)), 1'b0});
        @(posedge clk);
        #1 st_valid = 1'b0;
    endtask

    // Wait (bounded) until every predicted beat and completion has been seen.
    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (beat_q.size() == 0 && done_q.size() == 0 && st_ready) return;
        end
        check("idle_timeout", beat_q.size() + done_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        funct3   = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_st_ready", st_ready, 0);
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wstrb", mem_wstrb, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", st_ready, 1);

        // Byte into the top lane, halfword split, word split with waits, address wrap.
        ack_wait = 0; do_store(32'h0000_1003, 32'h1234_5678, 3'b000, 0); wait_idle();
        ack_wait = 0; do_store(32'h0000_2003, 32'h0000_BEEF, 3'b001, 0); wait_idle();
        ack_wait = 2; do_store(32'h0000_3002, 32'hAABB_CCDD, 3'b010, 0); wait_idle();
        ack_wait = 0; do_store(32'hFFFF_FFFE, 32'h1122_3344, 3'b010, 0); wait_idle();

        // Invalid encodings are rejected without a memory write.
        do_store(32'h0000_0040, 32'hDEAD_BEEF, 3'b011, 0); wait_idle();
        do_store(32'h0000_0044, 32'hCAFE_F00D, 3'b111, 0); wait_idle();

        // Back-to-back requests while busy; upper data bits must be masked off.
        ack_wait = 0; do_store(32'h0000_0100, 32'h0102_0304, 3'b010, 0);
        do_store(32'h0000_0105, 32'hFFFF_FF5A, 3'b000, 0); wait_idle();
        ack_wait = 1; do_store(32'h0000_0202, 32'h9876_ABCD, 3'b001, 0);
        do_store(32'h0000_0301, 32'h5555_1234, 3'b001, 0); wait_idle();
        ack_wait = 3; do_store(32'h0000_0401, 32'h0BAD_F00D, 3'b010, 0); wait_idle();

        // Reset while the second beat of a split store waits for its ack.
        ack_wait = 0;
        hold_ok  = 1;
        do_store(32'h0000_4003, 32'h0000_A5C3, 3'b001, 1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (beat_q.size() == 0 && mem_req) break;
        end
        repeat (2) @(negedge clk);
        check("abandon_second_addr", mem_addr, 32'h0000_4004);
        check("abandon_second_req", mem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_mem_req", mem_req, 0);
        check("midrst_st_ready", st_ready, 0);
        check("midrst_stall", stall, 0);
        check("midrst_mem_wstrb", mem_wstrb, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_done", done, 0);
        rst       = 1'b0;
        drv_en    = 0;
        force_ack = 1;
        repeat (3) begin
            @(negedge clk);
            check("late_ack_mem_req", mem_req, 0);
            check("late_ack_ready", st_ready, 1);
        end
        force_ack = 0;
        @(negedge clk);
        drv_en  = 1;
        hold_ok = 0;
        ack_wait = 0; do_store(32'h0000_5000, 32'h7654_3210, 3'b010, 0); wait_idle();

        repeat (3) @(negedge clk);
        check("beats_left", beat_q.size(), 0);
        check("dones_left", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/store_aligner.md
# store_aligner

Store-side counterpart to the load data-extraction logic in writeback. Accepts a store from the execute stage (byte address, rs2 data, funct3 width), converts it into one or two word-aligned data-memory write transactions with byte strobes, and holds the pipeline via a stall output until memory acknowledges. Misaligned halfword and word stores that cross a word boundary are split into two sequential word writes.

## Interface
- ADDR_W, 32: byte address width; memory addresses are word-aligned, so bits [1:0] are always 0.

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- st_valid  in  1  store request from execute
- st_ready  out  1  unit can accept a request; high only in IDLE and not in reset
- st_addr  in  ADDR_W  byte address of the store
- st_data  in  32  rs2 value; low bits are used per width
- funct3  in  3  000 SB, 001 SH, 010 SW; every other value is invalid
- mem_req  out  1  write request to data memory
- mem_ack  in  1  memory has accepted the current write
- mem_addr  out  ADDR_W  word-aligned write address
- mem_wdata  out  32  lane-aligned write data
- mem_wstrb  out  4  byte enables; bit i covers mem_wdata[8i+7:8i]
- stall  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse when a store completes
- err  out  1  one-cycle pulse when an invalid funct3 is rejected

## Operation
- FSM states: IDLE, FIRST, SECOND.
- Accept a request when st_valid and st_ready are both high. At acceptance, register:
  - word base = {st_addr[ADDR_W-1:2], 2'b00}
  - 64-bit shifted data = zero-extended width-masked st_data << (8 × st_addr[1:0])
  - 8-bit strobe = mask << st_addr[1:0], where the mask is 0001 for SB, 0011 for SH, 1111 for SW
  - split flag = strobe[7:4] != 0
- Invalid funct3 on accept: no memory transaction. err and done pulse in the following cycle. State stays IDLE.
- FIRST:
  - mem_req=1, mem_addr=base, mem_wdata=shifted[31:0], mem_wstrb=strobe[3:0]
  - On mem_ack: go to SECOND if split, else go to IDLE.
- SECOND:
  - mem_req=1, mem_addr=base+4 (modulo 2^ADDR_W), mem_wdata=shifted[63:32], mem_wstrb=strobe[7:4]
  - On mem_ack: go to IDLE.
- Byte lanes not covered by the strobe are driven 0 in mem_wdata.
- mem_addr, mem_wdata and mem_wstrb are registered. They are held stable while mem_req is high until mem_ack.
- mem_ack is ignored when mem_req is low.
- done pulses in the cycle after the final mem_ack, which is the same cycle st_ready returns high.

## Timing
- Reset values: mem_req 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, done 0, err 0, stall 0, st_ready 0 while rst is high. State is IDLE.
- Accept at cycle N: mem_req rises at N+1.
- Ack at N+1 (zero wait) for an aligned store: done at N+2. Peak throughput is one aligned store per 2 cycles.
- Split store with zero-wait acks: mem_req stays high for N+1..N+2, done at N+3.
- Each wait cycle (mem_ack low while mem_req high) extends latency by exactly one cycle.
- st_valid while busy: st_ready is low and the request is not consumed. Upstream holds st_valid, st_addr, st_data and funct3.
- rst asserted mid-transaction: the next edge returns to IDLE with all outputs at reset values. The pending store is abandoned with no done. A late mem_ack is ignored.
- Address wrap: SECOND at base 0xFFFFFFFC issues address 0x00000000.

## Test plan
- SB, addr 0x00001003, data 0x12345678, ack same cycle -> one write: addr 0x00001000, wdata 0x78000000, wstrb 1000; done two cycles after accept.
- SH, addr 0x00002003, data 0x0000BEEF -> first write: 0x00002000, 0xEF000000, 1000; second write: 0x00002004, 0x000000BE, 0001; then done.
- SW, addr 0x00003002, data 0xAABBCCDD, 2 wait cycles on each ack -> writes (0x00003000, 0xCCDD0000, 1100) then (0x00003004, 0x0000AABB, 0011). Outputs are stable during waits and stall is high throughout.
- SW, addr 0xFFFFFFFE -> second write address wraps to 0x00000000.
- funct3 011 with st_valid -> err and done pulse one cycle later; mem_req never rises.
- Reset asserted during SECOND while waiting for ack -> next cycle mem_req 0 and st_ready 0; a later ack is ignored; no done; normal SW accepted after reset is released.
